// File: rtl/cp0_if.sv
// cp0_if: M-stage side of the coprocessor-0 controller.
//   master (pipeline): drives A1/A2/DIn/We/EXLClr, PC_M/BD_M/ExcCode_M and HWInt;
//                      receives IntReq, EPC and DOut.
//   slave  (cp0):      the reverse.
interface cp0_if;
    logic [4:0]  A1;         // mfc0 read register number
    logic [4:0]  A2;         // mtc0 write register number
    logic [31:0] DIn;        // mtc0 write data
    logic        We;         // mtc0 in M stage
    logic        EXLClr;     // eret in M stage
    logic [31:0] PC_M;       // PC of M-stage instruction
    logic        BD_M;       // M-stage instruction is in a delay slot
    logic [6:2]  ExcCode_M;  // pending exception code, 0 = none
    logic [7:2]  HWInt;      // level-sensitive hardware interrupt lines
    logic        IntReq;     // take exception/interrupt this cycle
    logic [31:0] EPC;        // current EPC register
    logic [31:0] DOut;       // mfc0 read data

    modport master (
        output A1, A2, DIn, We, EXLClr, PC_M, BD_M, ExcCode_M, HWInt,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, EXLClr, PC_M, BD_M, ExcCode_M, HWInt,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt controller at the end of the M stage.
// Decides each cycle whether the M-stage instruction is taken as an exception
// or interrupt, records SR/Cause/EPC on a take, and serves mfc0/mtc0/eret.
//   clk    system clock, all state on rising edge
//   reset  asynchronous, active-low
//   bus    cp0_if.slave: M-stage controls in, IntReq/EPC/DOut out
module cp0 #(
    parameter logic [31:0] PRID   = 32'h4D49_5053,
    parameter logic [5:0]  IM_RST = 6'b111111
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);
    // SR fields
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    // Cause fields
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic [31:0] epc_src;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = ie & ~exl & (|(bus.HWInt & im));
    assign exc_req = (bus.ExcCode_M != 5'd0) & ~exl;
    assign take    = int_req | exc_req;

    // A delay-slot instruction restarts at its branch; subtraction wraps.
    assign epc_src = bus.BD_M ? (bus.PC_M - 32'd4) : bus.PC_M;

    assign sr_val    = {16'h0, im, 8'h0, exl, ie};
    assign cause_val = {bd, 15'h0, ip, 3'b000, exc_code, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= IM_RST;
            exl      <= 1'b0;
            ie       <= 1'b1;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= bus.HWInt;
            if (take) begin
                // Interrupts outrank exceptions; a pending mtc0 is dropped.
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : bus.ExcCode_M;
                bd       <= bus.BD_M;
                epc      <= {epc_src[31:2], 2'b00};
            end else begin
                if (bus.We && bus.A2 == 5'd12) begin
                    im  <= bus.DIn[15:10];
                    exl <= bus.DIn[1];
                    ie  <= bus.DIn[0];
                end
                if (bus.We && bus.A2 == 5'd14)
                    epc <= {bus.DIn[31:2], 2'b00};
                // eret clears EXL even when an SR write lands in the same cycle.
                if (bus.EXLClr)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = sr_val;
            5'd13:   bus.DOut = cause_val;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID;
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.IntReq = take;
    assign bus.EPC    = epc;
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: table-driven check of cp0. Each row is one cycle: inputs are driven
// after the falling edge, combinational outputs checked, then the next rising
// edge commits the row. Async reset is exercised by a hand-written sequence.
module tb_cp0;
    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk;
    logic reset;
    cp0_if bus();

    cp0 #(.PRID(PRID), .IM_RST(6'b111111)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic        clr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] din, input logic we,
                                input logic clr, input logic [31:0] pc,
                                input logic bd, input logic [4:0] exc,
                                input logic [5:0] hw, input logic req,
                                input logic [31:0] dout, input logic [31:0] epc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.clr = clr;
        v.pc = pc; v.bd = bd; v.exc = exc; v.hw = hw;
        v.exp_req = req; v.exp_dout = dout; v.exp_epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.A1 = v.a1; bus.A2 = v.a2; bus.DIn = v.din; bus.We = v.we;
        bus.EXLClr = v.clr; bus.PC_M = v.pc; bus.BD_M = v.bd;
        bus.ExcCode_M = v.exc; bus.HWInt = v.hw;
    endtask

    initial begin
        //            a1  a2  din          we clr pc           bd exc  hw     req dout          epc
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC01, 32'h0));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0,         32'h0));
        vecs.push_back(mk(14, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0,         32'h0));
        vecs.push_back(mk(15, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, PRID,          32'h0));
        vecs.push_back(mk(0,  0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0,         32'h0));
        // exception code 4, not in a delay slot
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h3010,     0, 4,  6'h00, 1, 32'h0000_FC01, 32'h0));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h3010,     0, 4,  6'h00, 0, 32'h0000_0010, 32'h3010));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC03, 32'h3010));
        vecs.push_back(mk(12, 0, 32'h0,        0, 1, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC03, 32'h3010));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC01, 32'h3010));
        // interrupt beats exception, delay slot
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h3020,     1, 10, 6'h01, 1, 32'h0000_0010, 32'h3010));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h01, 0, 32'h8000_0400, 32'h301C));
        vecs.push_back(mk(12, 0, 32'h0,        0, 1, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC03, 32'h301C));
        // IM masking through mtc0 SR
        vecs.push_back(mk(12, 12, 32'h0000_0401, 1, 0, 32'h0,      0, 0,  6'h00, 0, 32'h0000_FC01, 32'h301C));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h02, 0, 32'h0000_0401, 32'h301C));
        vecs.push_back(mk(13, 12, 32'h0000_0801, 1, 0, 32'h0,      0, 0,  6'h02, 0, 32'h8000_0800, 32'h301C));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h3030,     0, 0,  6'h02, 1, 32'h0000_0801, 32'h301C));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0800, 32'h3030));
        vecs.push_back(mk(12, 0, 32'h0,        0, 1, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0803, 32'h3030));
        // mtc0 EPC discarded by a simultaneous take
        vecs.push_back(mk(14, 14, 32'h1234_5677, 1, 0, 32'h3040,   0, 12, 6'h00, 1, 32'h3030,      32'h3030));
        vecs.push_back(mk(14, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h3040,      32'h3040));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0030, 32'h3040));
        vecs.push_back(mk(12, 0, 32'h0,        0, 1, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0803, 32'h3040));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0801, 32'h3040));
        // EPC write clears low bits; Cause write ignored
        vecs.push_back(mk(14, 14, 32'hABCD_0007, 1, 0, 32'h0,      0, 0,  6'h00, 0, 32'h3040,      32'h3040));
        vecs.push_back(mk(14, 13, 32'hFFFF_FFFF, 1, 0, 32'h0,      0, 0,  6'h00, 0, 32'hABCD_0004, 32'hABCD_0004));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_0030, 32'hABCD_0004));
        // delay slot at PC 2: EPC wraps below zero
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h2,        1, 8,  6'h00, 1, 32'h0000_0801, 32'hABCD_0004));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h8000_0020, 32'hFFFF_FFFC));
        // eret together with an SR write
        vecs.push_back(mk(12, 12, 32'h0000_F402, 1, 1, 32'h0,      0, 0,  6'h00, 0, 32'h0000_0803, 32'hFFFF_FFFC));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h3F, 0, 32'h0000_F400, 32'hFFFF_FFFC));
        vecs.push_back(mk(13, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h8000_FC20, 32'hFFFF_FFFC));
        // re-arm and enter a handler at 0x3040
        vecs.push_back(mk(12, 12, 32'h0000_FC01, 1, 0, 32'h0,      0, 0,  6'h00, 0, 32'h0000_F400, 32'hFFFF_FFFC));
        vecs.push_back(mk(14, 0, 32'h0,        0, 0, 32'h3040,     0, 12, 6'h00, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(12, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6'h00, 0, 32'h0000_FC03, 32'h3040));

        reset = 1'b0;
        drive(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d IntReq", i), {31'd0, bus.IntReq}, {31'd0, vecs[i].exp_req});
            check($sformatf("row%0d DOut", i), bus.DOut, vecs[i].exp_dout);
            check($sformatf("row%0d EPC", i), bus.EPC, vecs[i].exp_epc);
        end

        // Async reset mid-handler: registers clear without a clock edge.
        @(negedge clk);
        drive(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre-reset SR", bus.DOut, 32'h0000_FC03);
        reset = 1'b0;
        #1;
        check("async SR", bus.DOut, 32'h0000_FC01);
        check("async IntReq", {31'd0, bus.IntReq}, 32'd0);
        bus.A1 = 5'd13;
        #1;
        check("async Cause", bus.DOut, 32'h0);
        bus.A1 = 5'd14;
        #1;
        check("async EPC read", bus.DOut, 32'h0);
        check("async EPC port", bus.EPC, 32'h0);

        // Reset held across an edge, then released.
        @(negedge clk);
        reset = 1'b1;
        bus.A1 = 5'd15;
        #1;
        check("post-reset PRId", bus.DOut, PRID);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller at the far end of the Memory-stage pipeline interface: consumes the M-stage PC, branch-delay flag and exception code carried down the pipeline, plus the six hardware interrupt lines from the timers and peripherals. Decides each cycle whether the M-stage instruction is taken as an exception or interrupt. On a take, records SR/Cause/EPC and raises `IntReq` so the pipeline flushes and redirects to the handler. Also serves `mfc0`/`mtc0`/`eret` for the M-stage instruction.

## Interface
Parameters:
- `PRID`, 32'h4D49_5053, read-only processor ID value (register 15)
- `IM_RST`, 6'b111111, reset value of SR.IM

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `A1`  in  5  `mfc0` read register number
- `A2`  in  5  `mtc0` write register number
- `DIn`  in  32  `mtc0` write data
- `We`  in  1  `mtc0` in M stage
- `EXLClr`  in  1  `eret` in M stage
- `PC_M`  in  32  PC of M-stage instruction
- `BD_M`  in  1  M-stage instruction sits in a branch delay slot
- `ExcCode_M`  in  [6:2]  pending exception code of M-stage instruction; 0 = none
- `HWInt`  in  [7:2]  hardware interrupt lines, level-sensitive
- `IntReq`  out  1  take exception/interrupt this cycle (combinational)
- `EPC`  out  32  current EPC register, for `eret` redirect
- `DOut`  out  32  `mfc0` read data (combinational)

## Operation
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): constant `PRID`.
- Reset (`reset`=0, immediate): SR = {16'h0, `IM_RST`, 8'h0, 2'b01} (default 0x0000_FC01), Cause = 0, EPC = 0. Consequently `IntReq`=0 (ExcCode_M is forced 0 by upstream bubbles); `DOut` reflects the reset register values.
- Request logic, combinational:
  - `int_req` = IE & ~EXL & |(HWInt & IM).
  - `exc_req` = (ExcCode_M != 0) & ~EXL.
  - `IntReq` = `int_req` | `exc_req`.
- Take (at a clock edge with `IntReq`=1):
  - EXL <= 1.
  - Cause.ExcCode <= 0 if `int_req`, else ExcCode_M. Interrupts have priority over exceptions.
  - Cause.BD <= BD_M.
  - EPC <= (BD_M ? PC_M − 4 : PC_M) with bits [1:0] cleared; subtraction wraps modulo 2^32.
- Cause.IP <= HWInt on every edge, unconditionally.
- `mtc0` (`We`=1, `IntReq`=0):
  - A2=12: IM/EXL/IE <= DIn[15:10]/DIn[1]/DIn[0].
  - A2=14: EPC <= {DIn[31:2], 2'b00}.
  - Any other A2: ignored (Cause and PRId are not writable).
- `We`=1 with `IntReq`=1: write discarded, take wins.
- `EXLClr`=1: EXL <= 0. `IntReq` is necessarily 0 while EXL=1, so no conflict. `EXLClr` with `We` to SR in the same cycle: EXL <= 0, IM/IE from DIn.
- `DOut`: A1=12/13/14/15 → SR/Cause/EPC/PRId; any other value → 0. No write-to-read bypass.

## Timing
- `IntReq` is valid in the same cycle as ExcCode_M/HWInt, with zero latency. The pipeline flushes on that edge.
- SR/Cause/EPC updates are visible on `DOut`/`EPC` in the cycle after the edge.
- At most one take per instruction. After a take, EXL=1 masks further requests until `eret` retires in M.
- Cause.IP lags HWInt by one cycle. `int_req` uses live HWInt, not IP.
- Reset deassertion is asynchronous. The first functional edge is the first rising `clk` after `reset` goes high.

## Test plan
- Reset, then read A1=12/13/14/15 → 0x0000_FC01, 0, 0, `PRID`; `IntReq`=0.
- ExcCode_M=5'd4, PC_M=0x0000_3010, BD_M=0 → `IntReq`=1 same cycle. Next cycle: Cause=0x0000_0010, EPC=0x3010, SR.EXL=1. Repeat ExcCode_M=4 → `IntReq`=0.
- HWInt[2]=1 with ExcCode_M=5'd10, BD_M=1, PC_M=0x3020 → interrupt wins. Next cycle: Cause = 0x8000_0400 (BD, IP2, ExcCode 0), EPC=0x301C.
- `mtc0` SR←0x0000_0401 with HWInt[3]=1 → no request (IM3=0). Then `mtc0` SR←0x0000_0801 → `IntReq`=1 on the following cycle while HWInt[3] stays high.
- `We`=1, A2=14, DIn=0x1234_5677 together with ExcCode_M=5'd12, PC_M=0x3040 → EPC=0x3040, write discarded. After `eret` (EXLClr=1): EXL=0, EPC unchanged.
- Assert `reset`=0 mid-handler with EXL=1 and EPC=0x3040 → SR=0x0000_FC01, Cause=0, EPC=0 immediately, without a clock edge.
